// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: decodes one instruction into a registered slot and
// holds it back while a busy-bit scoreboard reports a pending register write.
module decode_issue_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1_index,
  output logic [4:0]      rs2_index,
  output logic [4:0]      rd_index,
  output logic            rd_we,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      op_class,
  output logic            illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush
);

  localparam logic [3:0] OC_LUI     = 4'd0;
  localparam logic [3:0] OC_AUIPC   = 4'd1;
  localparam logic [3:0] OC_JAL     = 4'd2;
  localparam logic [3:0] OC_JALR    = 4'd3;
  localparam logic [3:0] OC_BRANCH  = 4'd4;
  localparam logic [3:0] OC_LOAD    = 4'd5;
  localparam logic [3:0] OC_STORE   = 4'd6;
  localparam logic [3:0] OC_OPIMM   = 4'd7;
  localparam logic [3:0] OC_OP      = 4'd8;
  localparam logic [3:0] OC_SYS     = 4'd9;
  localparam logic [3:0] OC_ILLEGAL = 4'd15;

  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [3:0]  dec_class;
  logic [31:0] dec_imm32;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic        dec_writes;
  logic        dec_rd_we;
  logic        dec_illegal;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] busy_eff;
  logic            hazard;
  logic            accept;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [4:0]      rs1_index_q, rs1_index_d;
  logic [4:0]      rs2_index_q, rs2_index_d;
  logic [4:0]      rd_index_q, rd_index_d;
  logic            rd_we_q, rd_we_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [3:0]      op_class_q, op_class_d;
  logic            illegal_q, illegal_d;

  assign dec_opcode = in_instr[6:0];
  assign dec_rs1    = in_instr[19:15];
  assign dec_rs2    = in_instr[24:20];
  assign dec_rd     = in_instr[11:7];

  // Full 7-bit opcode match also rejects encodings whose low bits are not 2'b11.
  always_comb begin
    dec_class    = OC_ILLEGAL;
    dec_imm32    = '0;
    dec_rs1_used = 1'b0;
    dec_rs2_used = 1'b0;
    dec_writes   = 1'b0;
    case (dec_opcode)
      7'b0110111: begin
        dec_class  = OC_LUI;
        dec_imm32  = {in_instr[31:12], 12'b0};
        dec_writes = 1'b1;
      end
      7'b0010111: begin
        dec_class  = OC_AUIPC;
        dec_imm32  = {in_instr[31:12], 12'b0};
        dec_writes = 1'b1;
      end
      7'b1101111: begin
        dec_class  = OC_JAL;
        dec_imm32  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
        dec_writes = 1'b1;
      end
      7'b1100111: begin
        dec_class    = OC_JALR;
        dec_imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_rs1_used = 1'b1;
        dec_writes   = 1'b1;
      end
      7'b1100011: begin
        dec_class    = OC_BRANCH;
        dec_imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
      end
      7'b0000011: begin
        dec_class    = OC_LOAD;
        dec_imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_rs1_used = 1'b1;
        dec_writes   = 1'b1;
      end
      7'b0100011: begin
        dec_class    = OC_STORE;
        dec_imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
      end
      7'b0010011: begin
        dec_class    = OC_OPIMM;
        dec_imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_rs1_used = 1'b1;
        dec_writes   = 1'b1;
      end
      7'b0110011: begin
        dec_class    = OC_OP;
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_writes   = 1'b1;
      end
      7'b0001111, 7'b1110011: begin
        dec_class = OC_SYS;
      end
      default: ;
    endcase
  end

  assign dec_illegal = (dec_class == OC_ILLEGAL);
  assign dec_rd_we   = dec_writes && (dec_rd != 5'd0);

  // A writeback landing this cycle frees its register for the hazard check.
  assign wb_mask  = wb_valid ? (NREG'(1) << wb_rd) : '0;
  assign busy_eff = busy_q & ~wb_mask;

  assign hazard = in_valid && (
                    (dec_rs1_used && (dec_rs1 != 5'd0) && busy_eff[dec_rs1]) ||
                    (dec_rs2_used && (dec_rs2 != 5'd0) && busy_eff[dec_rs2]) ||
                    (dec_rd_we && busy_eff[dec_rd]));

  assign in_ready = !reset && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Clears (writeback, flushed slot) go first so a same-cycle issue set wins.
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (flush && out_valid_q && rd_we_q) begin
      busy_d[rd_index_q] = 1'b0;
    end
    if (accept && dec_rd_we) begin
      busy_d[dec_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    rs1_index_d = rs1_index_q;
    rs2_index_d = rs2_index_q;
    rd_index_d  = rd_index_q;
    rd_we_d     = rd_we_q;
    imm_d       = imm_q;
    op_class_d  = op_class_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      rs1_index_d = dec_rs1;
      rs2_index_d = dec_rs2;
      rd_index_d  = dec_rd;
      rd_we_d     = dec_rd_we;
      imm_d       = XLEN'($signed(dec_imm32));
      op_class_d  = dec_class;
      illegal_d   = dec_illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      rs1_index_q <= '0;
      rs2_index_q <= '0;
      rd_index_q  <= '0;
      rd_we_q     <= 1'b0;
      imm_q       <= '0;
      op_class_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      rs1_index_q <= rs1_index_d;
      rs2_index_q <= rs2_index_d;
      rd_index_q  <= rd_index_d;
      rd_we_q     <= rd_we_d;
      imm_q       <= imm_d;
      op_class_q  <= op_class_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign rs1_index = rs1_index_q;
  assign rs2_index = rs2_index_q;
  assign rd_index  = rd_index_q;
  assign rd_we     = rd_we_q;
  assign imm       = imm_q;
  assign op_class  = op_class_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: hand-decoded RV32I words, scoreboard
// stalls, backpressure, flush and reset, each checked against fixed values.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [4:0]  rd_index;
  logic        rd_we;
  logic [31:0] imm;
  logic [3:0]  op_class;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  int tests_run = 0;
  int tests_failed = 0;

  decode_issue_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rd_index(rd_index),
    .rd_we(rd_we), .imm(imm), .op_class(op_class), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
    out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_in_ready got %b exp 0", in_ready); end
    after_edge();
    after_edge();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_out_valid got %b exp 0", out_valid); end
    tests_run++; if (dut.busy_q !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_busy got %h exp 0", dut.busy_q); end
    tests_run++; if ({out_pc, imm, op_class, rd_we, illegal, rd_index, rs1_index, rs2_index} !== '0) begin
      tests_failed++; $display("[TB] FAIL rst_fields got pc=%h imm=%h cls=%0d we=%b ill=%b", out_pc, imm, op_class, rd_we, illegal);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_addi();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL addi_in_ready got %b exp 1", in_ready); end
    after_edge();
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL addi_valid got %b exp 1", out_valid); end
    tests_run++; if ({rd_index, rs1_index} !== {5'd1, 5'd0}) begin tests_failed++; $display("[TB] FAIL addi_idx got rd=%0d rs1=%0d exp 1 0", rd_index, rs1_index); end
    tests_run++; if (imm !== 32'd5) begin tests_failed++; $display("[TB] FAIL addi_imm got %h exp 5", imm); end
    tests_run++; if ({op_class, rd_we, illegal} !== {4'd7, 1'b1, 1'b0}) begin tests_failed++; $display("[TB] FAIL addi_class got cls=%0d we=%b ill=%b exp 7 1 0", op_class, rd_we, illegal); end
    tests_run++; if (out_pc !== 32'h100) begin tests_failed++; $display("[TB] FAIL addi_pc got %h exp 100", out_pc); end
    tests_run++; if (dut.busy_q !== 32'h2) begin tests_failed++; $display("[TB] FAIL addi_busy got %h exp 2", dut.busy_q); end
  endtask

  task automatic test_raw_stall();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00108133; in_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL raw_stall_%0d got %b exp 0", i, in_ready); end
      after_edge();
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_rd = 5'd1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL raw_bypass got %b exp 1", in_ready); end
    after_edge();
    tests_run++; if ({out_valid, op_class, rd_index, rs1_index, rs2_index} !== {1'b1, 4'd8, 5'd2, 5'd1, 5'd1}) begin
      tests_failed++; $display("[TB] FAIL raw_add got v=%b cls=%0d rd=%0d rs1=%0d rs2=%0d exp 1 8 2 1 1", out_valid, op_class, rd_index, rs1_index, rs2_index);
    end
    tests_run++; if (imm !== 32'h0) begin tests_failed++; $display("[TB] FAIL raw_imm got %h exp 0", imm); end
    tests_run++; if (dut.busy_q !== 32'h4) begin tests_failed++; $display("[TB] FAIL raw_busy got %h exp 4", dut.busy_q); end
    @(negedge clk);
    in_valid = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic test_store();
    wb_valid = 1'b1; wb_rd = 5'd2;
    after_edge();
    @(negedge clk);
    wb_valid = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE20AE23; in_pc = 32'h108;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL sw_in_ready got %b exp 1", in_ready); end
    after_edge();
    tests_run++; if ({op_class, rd_we} !== {4'd6, 1'b0}) begin tests_failed++; $display("[TB] FAIL sw_class got cls=%0d we=%b exp 6 0", op_class, rd_we); end
    tests_run++; if (imm !== 32'hFFFFFFFC) begin tests_failed++; $display("[TB] FAIL sw_imm got %h exp fffffffc", imm); end
    tests_run++; if ({rs1_index, rs2_index} !== {5'd1, 5'd2}) begin tests_failed++; $display("[TB] FAIL sw_idx got rs1=%0d rs2=%0d exp 1 2", rs1_index, rs2_index); end
    tests_run++; if (dut.busy_q !== 32'h0) begin tests_failed++; $display("[TB] FAIL sw_busy got %h exp 0", dut.busy_q); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00700293; in_pc = 32'h200; out_ready = 1'b1;
    after_edge();
    @(negedge clk);
    out_ready = 1'b0; in_instr = 32'h00900313; in_pc = 32'h204;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready_%0d got %b exp 0", i, in_ready); end
      after_edge();
      tests_run++; if ({out_valid, out_pc, rd_index, imm} !== {1'b1, 32'h200, 5'd5, 32'd7}) begin
        tests_failed++; $display("[TB] FAIL bp_hold_%0d got v=%b pc=%h rd=%0d imm=%h exp 1 200 5 7", i, out_valid, out_pc, rd_index, imm);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release got %b exp 1", in_ready); end
    after_edge();
    tests_run++; if ({out_valid, out_pc, rd_index, imm} !== {1'b1, 32'h204, 5'd6, 32'd9}) begin
      tests_failed++; $display("[TB] FAIL bp_next got v=%b pc=%h rd=%0d imm=%h exp 1 204 6 9", out_valid, out_pc, rd_index, imm);
    end
    tests_run++; if (dut.busy_q !== 32'h60) begin tests_failed++; $display("[TB] FAIL bp_busy got %h exp 60", dut.busy_q); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00000000; in_pc = 32'h300;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL ill0_ready got %b exp 1", in_ready); end
    after_edge();
    tests_run++; if ({illegal, op_class, rd_we, imm} !== {1'b1, 4'd15, 1'b0, 32'h0}) begin
      tests_failed++; $display("[TB] FAIL ill0 got ill=%b cls=%0d we=%b imm=%h exp 1 15 0 0", illegal, op_class, rd_we, imm);
    end
    tests_run++; if (dut.busy_q !== 32'h60) begin tests_failed++; $display("[TB] FAIL ill0_busy got %h exp 60", dut.busy_q); end
    @(negedge clk);
    in_instr = 32'h0000007F; in_pc = 32'h304;
    after_edge();
    tests_run++; if ({out_pc, illegal, op_class, rd_we} !== {32'h304, 1'b1, 4'd15, 1'b0}) begin
      tests_failed++; $display("[TB] FAIL ill7f got pc=%h ill=%b cls=%0d we=%b exp 304 1 15 0", out_pc, illegal, op_class, rd_we);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00100193; in_pc = 32'h400;
    after_edge();
    tests_run++; if ({out_valid, rd_we, dut.busy_q} !== {1'b1, 1'b1, 32'h68}) begin
      tests_failed++; $display("[TB] FAIL fl_load got v=%b we=%b busy=%h exp 1 1 68", out_valid, rd_we, dut.busy_q);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fl_ready got %b exp 0", in_ready); end
    after_edge();
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fl_valid got %b exp 0", out_valid); end
    tests_run++; if (dut.busy_q !== 32'h60) begin tests_failed++; $display("[TB] FAIL fl_busy got %h exp 60", dut.busy_q); end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset_during_stall();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h006283B3; in_pc = 32'h500;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rs_stall got %b exp 0", in_ready); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rs_ready_%0d got %b exp 0", i, in_ready); end
      after_edge();
      tests_run++; if ({out_valid, dut.busy_q} !== {1'b0, 32'h0}) begin
        tests_failed++; $display("[TB] FAIL rs_state_%0d got v=%b busy=%h exp 0 0", i, out_valid, dut.busy_q);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rs_resume got %b exp 1", in_ready); end
    after_edge();
    tests_run++; if ({out_valid, op_class, rd_index, rs1_index, rs2_index} !== {1'b1, 4'd8, 5'd7, 5'd5, 5'd6}) begin
      tests_failed++; $display("[TB] FAIL rs_add got v=%b cls=%0d rd=%0d rs1=%0d rs2=%0d exp 1 8 7 5 6", out_valid, op_class, rd_index, rs1_index, rs2_index);
    end
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00300393; in_pc = 32'h600;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL sw_waw got %b exp 0", in_ready); end
    wb_valid = 1'b1; wb_rd = 5'd7;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL sw_bypass got %b exp 1", in_ready); end
    after_edge();
    tests_run++; if ({imm, rd_index, dut.busy_q} !== {32'd3, 5'd7, 32'h80}) begin
      tests_failed++; $display("[TB] FAIL sw_setwin got imm=%h rd=%0d busy=%h exp 3 7 80", imm, rd_index, dut.busy_q);
    end
    @(negedge clk);
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd0;
    after_edge();
    tests_run++; if (dut.busy_q !== 32'h80) begin tests_failed++; $display("[TB] FAIL wb_x0 got %h exp 80", dut.busy_q); end
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw_stall();
    test_store();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_during_stall();
    test_set_wins();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- RV32I decode/issue stage that sits directly upstream of the register-file read stage.
- Accepts fetched instructions over a valid/ready handshake and decodes register indices, immediate and operation class into a registered output slot.
- Holds a busy-bit scoreboard so an instruction is not issued until its source and destination registers are free of pending writebacks.

Parameters:
XLEN, 32, data/immediate/PC width
NREG, 32, architectural register count; index width is 5

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  fetch offers an instruction
in_ready  out  1  stage accepts the instruction this cycle (combinational)
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  output slot holds a decoded instruction
out_ready  in  1  downstream consumes the slot this cycle
out_pc  out  XLEN  PC of the held instruction
rs1_index  out  5  instr[19:15]
rs2_index  out  5  instr[24:20]
rd_index  out  5  instr[11:7]
rd_we  out  1  instruction writes rd (forced 0 when rd=0)
imm  out  XLEN  sign-extended immediate
op_class  out  4  operation class
illegal  out  1  unsupported encoding
wb_valid  in  1  writeback retires a register write
wb_rd  in  5  register being written back
flush  in  1  kill the held instruction

Behaviour:
- Reset: out_valid=0; out_pc, indices, imm, op_class, rd_we and illegal = 0; all busy bits = 0. in_ready=0 while reset is high.
- op_class encoding: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP-IMM, 8 OP, 9 MISC-MEM/SYSTEM, 15 illegal.
- An encoding is illegal if instr[1:0]!=2'b11 or the opcode is outside the set above. Illegal instructions have rd_we=0, use no registers, op_class=15, illegal=1.
- Immediates follow the I/S/B/U/J formats, sign-extended to XLEN. imm=0 for OP, MISC-MEM/SYSTEM and illegal.
- Register usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - Index outputs always carry the raw instruction fields.
- Effective busy: busy_eff[r] = busy[r] & ~(wb_valid && wb_rd==r). Writeback bypasses the stall in the same cycle.
- Hazard: in_valid and any of:
  - rs1 used with rs1!=0 and busy_eff[rs1];
  - rs2 used with rs2!=0 and busy_eff[rs2];
  - rd_we and busy_eff[rd] (WAW).
- in_ready = !reset && !flush && !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, the slot loads the decode of in_instr/in_pc next cycle with out_valid=1 (latency 1). If rd_we, busy[rd] is set.
- If out_valid && out_ready && !accept, out_valid clears next cycle. While the slot is held (out_valid && !out_ready), all outputs are stable.
- Busy updates in the same cycle: the wb clear applies first, then the issue set. Set wins when both target the same register.
- busy[0] is never set.
- flush has priority over accept:
  - out_valid clears next cycle.
  - If the killed slot had rd_we, its busy[rd_index] clears.
  - Other busy bits are untouched (older instructions are still in flight).
- wb_valid with a non-busy register, or with wb_rd=0, has no effect.

Test Plan:
1. After reset, present ADDI x1,x0,5 (0x00500093) with out_ready=1 -> accepted at once. Next cycle: out_valid=1, rd_index=1, rs1_index=0, imm=5, op_class=7, rd_we=1, busy[1]=1.
2. Next, present ADD x2,x1,x1 (0x00108133) -> in_ready=0 for every cycle busy[1] is set. Pulse wb_valid with wb_rd=1 -> accepted in that same cycle; op_class=8, busy[2]=1, busy[1]=0.
3. SW x2,-4(x1) (0xFE20AE23) with x1/x2 free -> op_class=6, imm=0xFFFFFFFC, rs1=1, rs2=2, rd_we=0, no busy bit set.
4. Hold out_ready=0 with the slot full and a second instruction offered -> in_ready=0 and outputs unchanged for 5 cycles. Raise out_ready -> the second instruction loads the following cycle.
5. Present 0x00000000 -> illegal=1, op_class=15, rd_we=0, imm=0, no busy change. Then 0x0000007F -> illegal=1.
6. Slot holds ADDI x3,x0,1 (0x00100193), assert flush -> out_valid=0 next cycle and busy[3]=0. Assert reset during a stall -> out_valid=0, all busy bits 0, in_ready=0 while reset is high.
